// File: rtl/rd_dest_scoreboard_pkg.sv
// rd_dest_scoreboard_pkg: shared types and constants for the destination scoreboard.
package rd_dest_scoreboard_pkg;
    localparam int DEPTH_DEF = 3;
    localparam int SELW_DEF = 2;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int FWD_RF = 0;
    typedef struct packed {
        logic vld;
        logic [4:0] addr;
        logic is_load;
    } entry_t;
endpackage

// File: rtl/rd_dest_scoreboard_src_match.sv
// rd_src_match: compares one decode source against in-flight destinations; youngest hit wins.
module rd_src_match
    import rd_dest_scoreboard_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int SELW = SELW_DEF
) (
    input  logic                    use_src,
    input  logic [4:0]              addr,
    input  entry_t [DEPTH-1:0]      stages,
    output logic                    hit,
    output logic [SELW-1:0]         k,
    output logic                    is_load
);
    always_comb begin
        hit = 1'b0;
        k = SELW'(FWD_RF);
        is_load = 1'b0;
        // scan oldest to youngest so the youngest match is the last one written
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (use_src && addr != REG_ZERO && stages[i].vld && stages[i].addr == addr) begin
                hit = 1'b1;
                k = SELW'(i + 1);
                is_load = stages[i].is_load;
            end
        end
    end
endmodule

// File: rtl/rd_dest_scoreboard.sv
// rd_dest_scoreboard: tracks in-flight destinations, drives writeback, forwarding selects and stall.
module rd_dest_scoreboard
    import rd_dest_scoreboard_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter bit FWD_EN = 1'b1,
    parameter int SELW = SELW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic            id_rd_en,
    input  logic [4:0]      id_rd_addr,
    input  logic            id_is_load,
    input  logic [4:0]      id_rs_addr,
    input  logic            id_rs_use,
    input  logic [4:0]      id_rt_addr,
    input  logic            id_rt_use,
    input  logic            flush,
    output logic            stall,
    output logic [SELW-1:0] fwd_rs_sel,
    output logic [SELW-1:0] fwd_rt_sel,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [31:0]     busy_map
);
    entry_t [DEPTH-1:0] st;
    entry_t nxt;
    logic rs_hit, rt_hit, rs_ld, rt_ld, acc;
    logic [SELW-1:0] rs_k, rt_k;

    rd_src_match #(.DEPTH(DEPTH), .SELW(SELW)) u_rs (
        .use_src(id_rs_use), .addr(id_rs_addr), .stages(st),
        .hit(rs_hit), .k(rs_k), .is_load(rs_ld)
    );
    rd_src_match #(.DEPTH(DEPTH), .SELW(SELW)) u_rt (
        .use_src(id_rt_use), .addr(id_rt_addr), .stages(st),
        .hit(rt_hit), .k(rt_k), .is_load(rt_ld)
    );

    assign stall = FWD_EN ? ((rs_hit & rs_ld & rs_k == SELW'(1)) | (rt_hit & rt_ld & rt_k == SELW'(1)))
                          : (rs_hit | rt_hit);
    assign fwd_rs_sel = FWD_EN ? rs_k : SELW'(FWD_RF);
    assign fwd_rt_sel = FWD_EN ? rt_k : SELW'(FWD_RF);
    assign acc = id_valid & id_rd_en & ~flush & ~stall & (id_rd_addr != REG_ZERO);
    // bubbles carry a zero address so wb_addr reads 0 whenever nothing retires
    assign nxt = '{vld: acc, addr: acc ? id_rd_addr : REG_ZERO, is_load: acc & id_is_load};
    assign wb_en = st[DEPTH-1].vld;
    assign wb_addr = st[DEPTH-1].addr;

    always_ff @(posedge clk) begin
        if (rst)
            st <= '0;
        else
            st <= {st[DEPTH-2:0], nxt};
    end

    always_comb begin
        busy_map = '0;
        for (int i = 0; i < DEPTH; i++)
            if (st[i].vld)
                busy_map[st[i].addr] = 1'b1;
    end
endmodule

// File: tb/tb_rd_dest_scoreboard.sv
// tb_rd_dest_scoreboard: directed checks of forwarding, stall, writeback and reset behaviour.
module tb_rd_dest_scoreboard;
    logic clk = 1'b0;
    logic rst, id_valid, id_rd_en, id_is_load, id_rs_use, id_rt_use, flush;
    logic [4:0] id_rd_addr, id_rs_addr, id_rt_addr;
    logic stall, wb_en, stall0, wb_en0;
    logic [1:0] fwd_rs_sel, fwd_rt_sel, fwd_rs_sel0, fwd_rt_sel0;
    logic [4:0] wb_addr, wb_addr0;
    logic [31:0] busy_map, busy_map0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rd_dest_scoreboard #(.DEPTH(3), .FWD_EN(1'b1), .SELW(2)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd_en(id_rd_en), .id_rd_addr(id_rd_addr),
        .id_is_load(id_is_load), .id_rs_addr(id_rs_addr), .id_rs_use(id_rs_use),
        .id_rt_addr(id_rt_addr), .id_rt_use(id_rt_use), .flush(flush), .stall(stall),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .wb_en(wb_en), .wb_addr(wb_addr),
        .busy_map(busy_map)
    );

    rd_dest_scoreboard #(.DEPTH(3), .FWD_EN(1'b0), .SELW(2)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd_en(id_rd_en), .id_rd_addr(id_rd_addr),
        .id_is_load(id_is_load), .id_rs_addr(id_rs_addr), .id_rs_use(id_rs_use),
        .id_rt_addr(id_rt_addr), .id_rt_use(id_rt_use), .flush(flush), .stall(stall0),
        .fwd_rs_sel(fwd_rs_sel0), .fwd_rt_sel(fwd_rt_sel0), .wb_en(wb_en0), .wb_addr(wb_addr0),
        .busy_map(busy_map0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rd_en = 0; id_rd_addr = 0; id_is_load = 0;
        id_rs_use = 0; id_rs_addr = 0; id_rt_use = 0; id_rt_addr = 0; flush = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic ld);
        idle();
        id_valid = 1; id_rd_en = 1; id_rd_addr = rd; id_is_load = ld;
    endtask

    initial begin
        rst = 1;
        idle();
        tick();
        tick();
        rst = 0;
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_rs_sel", 32'(fwd_rs_sel), 0);
        chk("rst_rt_sel", 32'(fwd_rt_sel), 0);
        chk("rst_wb_en", 32'(wb_en), 0);
        chk("rst_wb_addr", 32'(wb_addr), 0);
        chk("rst_busy", busy_map, 0);

        // ALU result forwarded from stage 1, retires DEPTH edges after issue
        issue(5'd5, 0);
        #1 chk("add_issue_stall", 32'(stall), 0);
        tick();
        idle(); id_valid = 1; id_rs_use = 1; id_rs_addr = 5'd5;
        #1;
        chk("add_fwd_rs", 32'(fwd_rs_sel), 1);
        chk("add_no_stall", 32'(stall), 0);
        chk("add_busy", busy_map, 32'h20);
        tick();
        idle();
        #1 chk("add_wb_early", 32'(wb_en), 0);
        tick();
        chk("add_wb_en", 32'(wb_en), 1);
        chk("add_wb_addr", 32'(wb_addr), 5);
        tick();
        chk("add_wb_done", 32'(wb_en), 0);
        chk("add_busy_clr", busy_map, 0);

        // load-use: one bubble then forward from stage 2
        issue(5'd8, 1);
        tick();
        idle(); id_valid = 1; id_rt_use = 1; id_rt_addr = 5'd8;
        #1;
        chk("ld_stall", 32'(stall), 1);
        chk("ld_rt_sel1", 32'(fwd_rt_sel), 1);
        tick();
        chk("ld_stall_rel", 32'(stall), 0);
        chk("ld_rt_sel2", 32'(fwd_rt_sel), 2);
        idle();
        tick(); tick(); tick();
        chk("ld_drained", busy_map, 0);

        // r0 and rd_en=0 never tracked
        issue(5'd0, 0);
        tick();
        chk("r0_busy", busy_map, 0);
        idle(); id_valid = 1; id_rd_addr = 'x; id_rs_use = 1; id_rs_addr = 5'd0;
        #1;
        chk("r0_rs_sel", 32'(fwd_rs_sel), 0);
        chk("r0_stall", 32'(stall), 0);
        tick();
        chk("noen_busy", busy_map, 0);
        idle();
        tick();
        chk("r0_wb_en", 32'(wb_en), 0);
        tick();
        chk("noen_wb_en", 32'(wb_en), 0);
        tick();

        // two writes to r3 in flight, youngest wins
        issue(5'd3, 0);
        tick();
        issue(5'd3, 0);
        tick();
        idle(); id_valid = 1; id_rs_use = 1; id_rs_addr = 5'd3; id_rt_use = 1; id_rt_addr = 5'd3;
        #1;
        chk("yng_rs_sel", 32'(fwd_rs_sel), 1);
        chk("yng_rt_sel", 32'(fwd_rt_sel), 1);
        chk("yng_busy", busy_map, 32'h8);
        idle();
        tick(); tick(); tick();

        // no-forward variant
        rst = 1;
        tick();
        rst = 0;
        issue(5'd9, 0);
        tick();
        idle(); id_valid = 1; id_rs_use = 1; id_rs_addr = 5'd9; id_rd_en = 1; id_rd_addr = 5'd10;
        #1;
        chk("nf_stall1", 32'(stall0), 1);
        chk("nf_rs_sel", 32'(fwd_rs_sel0), 0);
        tick();
        chk("nf_stall2", 32'(stall0), 1);
        tick();
        chk("nf_stall3", 32'(stall0), 1);
        chk("nf_wb_en", 32'(wb_en0), 1);
        chk("nf_wb_addr", 32'(wb_addr0), 9);
        tick();
        chk("nf_stall_rel", 32'(stall0), 0);
        tick();
        chk("nf_r10_busy", busy_map0, 32'h400);
        idle(); id_valid = 1; id_rs_use = 1; id_rs_addr = 5'd10; id_rd_en = 1; id_rd_addr = 5'd11;
        flush = 1;
        #1 chk("fl_stall", 32'(stall0), 1);
        tick();
        chk("fl_no_entry", busy_map0, 32'h400);
        issue(5'd12, 0);
        tick();
        chk("mid_busy", busy_map0, 32'h1400);
        idle();
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("mid_rst_busy", busy_map0, 0);
        chk("mid_rst_wb", 32'(wb_en0), 0);
        tick();
        chk("mid_rst_wb2", 32'(wb_en0), 0);
        tick();
        chk("mid_rst_wb3", 32'(wb_en0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
